// File: rtl/mem_pkg.sv
// mem_pkg: shared encodings for the memory-access stage (access sizes, FSM states).
package mem_pkg;
  typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_e;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
endpackage

// File: rtl/mem_lane_fmt.sv
// mem_lane_fmt: combinational byte-lane logic, load extract/extend and store replicate/byte-enables.
module mem_lane_fmt import mem_pkg::*; #(
  parameter int XLEN = 64,
  localparam int NB = XLEN / 8,
  localparam int LW = $clog2(NB)
) (
  input  mem_size_e         ld_size_i,
  input  logic              ld_uns_i,
  input  logic [LW-1:0]     ld_lane_i,
  input  logic [XLEN-1:0]   rdata_i,
  output logic [XLEN-1:0]   load_o,
  input  mem_size_e         st_size_i,
  input  logic [LW-1:0]     st_lane_i,
  input  logic [XLEN-1:0]   wdata_i,
  output logic [XLEN-1:0]   wdata_o,
  output logic [NB-1:0]     be_o
);
  logic [XLEN-1:0] sh, mask;
  logic            sgn;
  assign sh   = rdata_i >> {ld_lane_i, 3'b000};
  // mask covers the accessed width; its top set bit marks the sign position
  assign mask = ~({XLEN{1'b1}} << (32'd8 << ld_size_i));
  assign sgn  = |(sh & mask & ~(mask >> 1)) && !(ld_uns_i && ld_size_i != MEM_D);
  assign load_o = (sh & mask) | (sgn ? ~mask : '0);
  assign wdata_o = st_size_i == MEM_B ? {NB{wdata_i[7:0]}} :
                   st_size_i == MEM_H ? {(NB/2){wdata_i[15:0]}} :
                   st_size_i == MEM_W ? {(NB/4){wdata_i[31:0]}} : wdata_i;
  assign be_o = ~({NB{1'b1}} << (4'd1 << st_size_i)) << st_lane_i;
endmodule

// File: rtl/mem_stage_ctrl.sv
// mem_stage_ctrl: memory-access pipeline stage, bus handshake FSM, stall and load/store formatting.
// Optional MEM_TIMEOUT_EN aborts a bus wait after MAX_WAIT cycles and pulses bus_err.
module mem_stage_ctrl import mem_pkg::*; #(
  parameter int XLEN = 64,
  parameter int MAX_WAIT = 15,
  localparam int NB = XLEN / 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ce,
  input  logic              mem_rw,
  input  logic [1:0]        mem_size,
  input  logic              mem_unsigned,
  input  logic [XLEN-1:0]   addr,
  input  logic [XLEN-1:0]   wdata,
  output logic              bus_req,
  output logic              bus_we,
  output logic [XLEN-1:0]   bus_addr,
  output logic [XLEN-1:0]   bus_wdata,
  output logic [NB-1:0]     bus_be,
  input  logic [XLEN-1:0]   bus_rdata,
  input  logic              bus_ready,
  output logic [XLEN-1:0]   result,
  output logic              stall,
  output logic              misalign,
  output logic              bus_err
);
  localparam int LW = $clog2(NB);
  state_e          state_q, state_d;
  mem_size_e       sz, size_q;
  logic            uns_q, we_q, mis, accept, tmo;
  logic [LW-1:0]   lane_q;
  logic [XLEN-1:0] addr_q, wdata_q, result_q, result_d, ld_data, st_data;
  logic [NB-1:0]   be_q, st_be;
  assign sz  = mem_size_e'(mem_size);
  assign mis = (sz == MEM_H && addr[0]) || (sz == MEM_W && |addr[1:0]) ||
               (sz == MEM_D && (XLEN == 32 || |addr[2:0]));
  assign misalign = ce && state_q == IDLE && mis;
  assign accept   = ce && state_q == IDLE && !mis;
  mem_lane_fmt #(.XLEN(XLEN)) u_fmt (
    .ld_size_i(size_q), .ld_uns_i(uns_q), .ld_lane_i(lane_q), .rdata_i(bus_rdata), .load_o(ld_data),
    .st_size_i(sz), .st_lane_i(addr[LW-1:0]), .wdata_i(wdata), .wdata_o(st_data), .be_o(st_be)
  );
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    stall    = 1'b0;
    if (state_q == IDLE) begin
      stall   = accept;
      state_d = accept ? BUSY : IDLE;
    end else if (state_q == BUSY) begin
      stall = 1'b1;
      if (bus_ready || tmo) begin
        state_d  = DONE;
        result_d = (bus_ready && !we_q) ? ld_data : '0;
      end
    end else begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      result_q <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
      size_q   <= MEM_B;
      uns_q    <= 1'b0;
      lane_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      if (accept) begin
        addr_q  <= {addr[XLEN-1:LW], {LW{1'b0}}};
        wdata_q <= st_data;
        be_q    <= st_be;
        we_q    <= mem_rw;
        size_q  <= sz;
        uns_q   <= mem_unsigned;
        lane_q  <= addr[LW-1:0];
      end
    end
  end
  assign bus_req   = state_q == BUSY;
  assign bus_we    = we_q;
  assign bus_addr  = addr_q;
  assign bus_wdata = wdata_q;
  assign bus_be    = be_q;
  assign result    = state_q == DONE ? result_q : addr;
`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(MAX_WAIT + 1);
  logic [CW-1:0] cnt_q;
  logic          err_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= accept ? '0 : (state_q == BUSY && !bus_ready && !tmo) ? cnt_q + 1'b1 : cnt_q;
      err_q <= state_q == BUSY && !bus_ready && tmo;
    end
  end
  assign tmo     = cnt_q == CW'(MAX_WAIT);
  assign bus_err = err_q;
`else
  assign tmo     = MAX_WAIT < 0;
  assign bus_err = 1'b0;
`endif
endmodule
